// File: rtl/instrumented_adder_meas_ctrl.sv
// instrumented_adder_meas_ctrl
//   Sequences one ring-oscillator timing measurement of the instrumented adder:
//   latch operands and one-hot bit selects, clear the ring counter, run the ring
//   for a programmed window, stop it, let the ring domain settle, then capture
//   the synchronised count for the host.
//
//   Optional feature macro: INSTR_CTRL_REPEAT_EN
//     When defined, adds cfg_repeat[3:0] and accumulates cfg_repeat+1 runs
//     into a saturating accumulator before a single done pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; outputs keep last configuration
//   SETUP   | operands/selects applied, ring counter held in clear
//   RUN     | ring oscillator enabled for the measurement window
//   DRAIN   | ring stopped, waiting for counter synchroniser to settle
//   CAPTURE | count sampled into result, done pulse (or next repeat run)
module instrumented_adder_meas_ctrl #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 32,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 4
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_a,
  input  logic [WIDTH-1:0] cfg_b,
  input  logic [4:0]       cfg_ext_idx,
  input  logic [4:0]       cfg_ring_idx,
  input  logic [4:0]       cfg_sout_idx,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic [CNT_W-1:0] count_in,
`ifdef INSTR_CTRL_REPEAT_EN
  input  logic [3:0]       cfg_repeat,
`endif
  output logic [WIDTH-1:0] a_input,
  output logic [WIDTH-1:0] b_input,
  output logic [WIDTH-1:0] ext_sel,
  output logic [WIDTH-1:0] ring_sel,
  output logic [WIDTH-1:0] sout_sel,
  output logic             ring_en,
  output logic             cnt_clear,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result
);

  // Timer must hold both the window and the settle count.
  localparam int TMR_W_MIN = $clog2(SETTLE) + 1;
  localparam int TMR_W     = (WIN_W > TMR_W_MIN) ? WIN_W : TMR_W_MIN;
  localparam logic [TMR_W-1:0] SETTLE_M1 = TMR_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic [WIN_W-1:0] win_m1;
  logic             timer_tc;
  logic             accept;
  logic             cap_edge;
  logic             cap_last;
  logic [CNT_W-1:0] cap_value;

  // Index outside the mask width yields an all-zero select (ring cannot close).
  function automatic logic [WIDTH-1:0] onehot(input logic [4:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign timer_tc = (timer == '0);
  assign accept   = (state == ST_IDLE) && start && !abort;
  // Only DRAIN leads into CAPTURE, and abort never allows it.
  assign cap_edge = (state_next == ST_CAPTURE);

`ifdef INSTR_CTRL_REPEAT_EN
  logic [3:0]       runs_left;
  logic             mean_mode;
  logic [CNT_W+3:0] acc;
  logic [CNT_W+4:0] acc_sum;
  logic [CNT_W+3:0] acc_sat;

  assign acc_sum   = {1'b0, acc} + (CNT_W+5)'(count_in);
  assign acc_sat   = acc_sum[CNT_W+4] ? '1 : acc_sum[CNT_W+3:0];
  assign cap_last  = (runs_left == 4'd0);
  // Sixteen runs divide cleanly by 16; any other count reports the raw sum.
  assign cap_value = mean_mode ? acc_sat[CNT_W+3:4] : acc_sat[CNT_W-1:0];

  // Repeat bookkeeping: run counter and saturating accumulator.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      runs_left <= '0;
      mean_mode <= 1'b0;
      acc       <= '0;
    end else begin
      if (accept) begin
        runs_left <= cfg_repeat;
        mean_mode <= (cfg_repeat == 4'hF);
        acc       <= '0;
      end else begin
        if (cap_edge) acc <= acc_sat;
        if (state == ST_CAPTURE && !cap_last) runs_left <= runs_left - 4'd1;
      end
    end
  end
`else
  assign cap_last  = 1'b1;
  assign cap_value = count_in;
`endif

  // Next-state and timer reload; abort overrides every transition.
  always_comb begin
    state_next = state;
    timer_next = timer_tc ? timer : timer - 1'b1;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SETUP;
          timer_next = SETTLE_M1;
        end
      end
      ST_SETUP: begin
        if (timer_tc) begin
          state_next = ST_RUN;
          timer_next = TMR_W'(win_m1);
        end
      end
      ST_RUN: begin
        if (timer_tc) begin
          state_next = ST_DRAIN;
          timer_next = SETTLE_M1;
        end
      end
      ST_DRAIN: begin
        if (timer_tc) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cap_last) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_SETUP;
          timer_next = SETTLE_M1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      timer_next = '0;
    end
  end

  // State register plus registered controls decoded from next state (glitch-free to analog).
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      win_m1    <= '0;
      a_input   <= '0;
      b_input   <= '0;
      ext_sel   <= '0;
      ring_sel  <= '0;
      sout_sel  <= '0;
      ring_en   <= 1'b0;
      cnt_clear <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      ring_en   <= (state_next == ST_RUN);
      cnt_clear <= (state_next == ST_SETUP);
      busy      <= (state_next != ST_IDLE);
      done      <= cap_edge && cap_last;
      if (accept) begin
        a_input  <= cfg_a;
        b_input  <= cfg_b;
        ext_sel  <= onehot(cfg_ext_idx);
        ring_sel <= onehot(cfg_ring_idx);
        sout_sel <= onehot(cfg_sout_idx);
        win_m1   <= (cfg_window == '0) ? '0 : cfg_window - 1'b1;
      end
      if (cap_edge && cap_last) result <= cap_value;
    end
  end

endmodule

// File: tb/tb_instrumented_adder_meas_ctrl.sv
// Bench for instrumented_adder_meas_ctrl: directed measurements with a
// scoreboard of expected done cycle, result and ring_en/cnt_clear durations.
module tb_instrumented_adder_meas_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] cfg_a;
  logic [31:0] cfg_b;
  logic [4:0]  cfg_ext_idx;
  logic [4:0]  cfg_ring_idx;
  logic [4:0]  cfg_sout_idx;
  logic [15:0] cfg_window;
  logic [31:0] count_in;
`ifdef INSTR_CTRL_REPEAT_EN
  logic [3:0]  cfg_repeat;
`endif
  logic [31:0] a_input;
  logic [31:0] b_input;
  logic [31:0] ext_sel;
  logic [31:0] ring_sel;
  logic [31:0] sout_sel;
  logic        ring_en;
  logic        cnt_clear;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
    int          ring_cycles;
    int          clr_cycles;
  } exp_t;

  exp_t sb_q[$];

  instrumented_adder_meas_ctrl dut (
    .wb_clk_i     (wb_clk_i),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_a        (cfg_a),
    .cfg_b        (cfg_b),
    .cfg_ext_idx  (cfg_ext_idx),
    .cfg_ring_idx (cfg_ring_idx),
    .cfg_sout_idx (cfg_sout_idx),
    .cfg_window   (cfg_window),
    .count_in     (count_in),
`ifdef INSTR_CTRL_REPEAT_EN
    .cfg_repeat   (cfg_repeat),
`endif
    .a_input      (a_input),
    .b_input      (b_input),
    .ext_sel      (ext_sel),
    .ring_sel     (ring_sel),
    .sout_sel     (sout_sel),
    .ring_en      (ring_en),
    .cnt_clear    (cnt_clear),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops one expectation per done pulse; counts ring_en/cnt_clear over the busy period.
  task automatic monitor();
    int   ring_n = 0;
    int   clr_n  = 0;
    exp_t e;
    forever begin
      @(negedge wb_clk_i);
      if (busy !== 1'b1) begin
        ring_n = 0;
        clr_n  = 0;
      end else begin
        if (ring_en === 1'b1) ring_n++;
        if (cnt_clear === 1'b1) clr_n++;
      end
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending measurement", cyc);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          check("result", 64'(result), 64'(e.res));
          check("ring_en_cycles", 64'(ring_n), 64'(e.ring_cycles));
          check("cnt_clear_cycles", 64'(clr_n), 64'(e.clr_cycles));
        end
      end
    end
  endtask

  // Issues a one-cycle start; done_off is the hand-computed edge offset of done from the start edge.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] ei, input logic [4:0] ri, input logic [4:0] si,
                          input logic [15:0] w, input bit push, input logic [31:0] res,
                          input int done_off, input int ring_c, input int clr_c);
    int k;
    @(negedge wb_clk_i);
    cfg_a        = a;
    cfg_b        = b;
    cfg_ext_idx  = ei;
    cfg_ring_idx = ri;
    cfg_sout_idx = si;
    cfg_window   = w;
    start        = 1'b1;
    k            = cyc + 1;
    if (push) sb_q.push_back('{res: res, done_cyc: k + done_off, ring_cycles: ring_c, clr_cycles: clr_c});
    @(negedge wb_clk_i);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) break;
      @(negedge wb_clk_i);
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic wait_ring(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (ring_en === 1'b1) break;
      @(negedge wb_clk_i);
    end
    check(name, 64'(ring_en), 64'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b1;
    abort        = 1'b0;
    cfg_a        = 32'hffff_ffff;
    cfg_b        = 32'hffff_ffff;
    cfg_ext_idx  = 5'd3;
    cfg_ring_idx = 5'd3;
    cfg_sout_idx = 5'd3;
    cfg_window   = 16'd7;
    count_in     = 32'd0;
`ifdef INSTR_CTRL_REPEAT_EN
    cfg_repeat   = 4'd0;
`endif

    // Reset held 2 cycles with start high: everything must be zero.
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ring_en", 64'(ring_en), 64'd0);
    check("rst_cnt_clear", 64'(cnt_clear), 64'd0);
    check("rst_a_input", 64'(a_input), 64'd0);
    check("rst_b_input", 64'(b_input), 64'd0);
    check("rst_ext_sel", 64'(ext_sel), 64'd0);
    check("rst_ring_sel", 64'(ring_sel), 64'd0);
    check("rst_sout_sel", 64'(sout_sel), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    fork
      monitor();
    join_none
    @(negedge wb_clk_i);
    check("post_rst_busy", 64'(busy), 64'd0);

    // Window 100: done 108 edges after the start edge (cycle 110 counting the start cycle).
    count_in = 32'd437;
    do_start(32'h0, 32'h0, 5'd12, 5'd12, 5'd12, 16'd100, 1'b1, 32'd437, 108, 100, 4);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_cnt_clear", 64'(cnt_clear), 64'd1);
    check("t2_ring_en_setup", 64'(ring_en), 64'd0);
    check("t2_ring_sel", 64'(ring_sel), 64'h0000_1000);
    check("t2_ext_sel", 64'(ext_sel), 64'h0000_1000);
    check("t2_sout_sel", 64'(sout_sel), 64'h0000_1000);
    wait_idle(200, "t2_idle");
    check("t2_result_hold", 64'(result), 64'd437);

    // Abort five cycles into RUN: no done, result keeps 437.
    count_in = 32'd999;
    do_start(32'h11, 32'h22, 5'd1, 5'd2, 5'd3, 16'd50, 1'b0, 32'd0, 0, 0, 0);
    wait_ring(20, "t4_ring_start");
    repeat (4) @(negedge wb_clk_i);
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    check("t4_ring_en", 64'(ring_en), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_cnt_clear", 64'(cnt_clear), 64'd0);
    check("t4_done", 64'(done), 64'd0);
    check("t4_result", 64'(result), 64'd437);
    repeat (70) @(negedge wb_clk_i);
    check("t4_result_late", 64'(result), 64'd437);

    // Window 0 behaves as 1: done 9 edges after start (cycle 11).
    count_in = 32'd11;
    do_start(32'h5, 32'h9, 5'd0, 5'd31, 5'd7, 16'd0, 1'b1, 32'd11, 9, 1, 4);
    check("t3_ring_sel", 64'(ring_sel), 64'h8000_0000);
    check("t3_ext_sel", 64'(ext_sel), 64'h0000_0001);
    check("t3_sout_sel", 64'(sout_sel), 64'h0000_0080);
    check("t3_a_input", 64'(a_input), 64'h5);
    check("t3_b_input", 64'(b_input), 64'h9);
    wait_idle(50, "t3_idle");

    // Start during RUN is ignored; done timing and operands unaffected.
    count_in = 32'd77;
    do_start(32'h1234_5678, 32'h0f0f_0f0f, 5'd4, 5'd5, 5'd6, 16'd20, 1'b1, 32'd77, 28, 20, 4);
    wait_ring(20, "t5_ring_start");
    @(negedge wb_clk_i);
    cfg_a      = 32'hdead_beef;
    cfg_window = 16'd3;
    start      = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    check("t5_a_during_run", 64'(a_input), 64'h1234_5678);
    check("t5_busy", 64'(busy), 64'd1);
    wait_idle(60, "t5_idle");
    check("t5_a_after_done", 64'(a_input), 64'h1234_5678);
    check("t5_ext_sel_after_done", 64'(ext_sel), 64'h0000_0010);

    // Start and abort together in IDLE: abort wins.
    @(negedge wb_clk_i);
    cfg_a = 32'hcafe_f00d;
    start = 1'b1;
    abort = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    abort = 1'b0;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_a_input", 64'(a_input), 64'h1234_5678);
    repeat (3) @(negedge wb_clk_i);
    check("t6_busy_late", 64'(busy), 64'd0);

`ifdef INSTR_CTRL_REPEAT_EN
    // Four runs of 250: one done after 4*(4+10+4+1)-1 = 75 edges, sum 1000.
    cfg_repeat = 4'd3;
    count_in   = 32'd250;
    do_start(32'h1, 32'h2, 5'd3, 5'd3, 5'd3, 16'd10, 1'b1, 32'd1000, 75, 40, 16);
    wait_idle(200, "t7_idle");
    // Sixteen runs of 160: mean 160, done after 16*(4+1+4+1)-1 = 159 edges.
    cfg_repeat = 4'd15;
    count_in   = 32'd160;
    do_start(32'h1, 32'h2, 5'd3, 5'd3, 5'd3, 16'd1, 1'b1, 32'd160, 159, 16, 64);
    wait_idle(400, "t7_mean_idle");
    cfg_repeat = 4'd0;
`endif

    // Reset mid-RUN: ring_en drops at the next edge, state as reset.
    count_in = 32'd5;
    do_start(32'haaaa_5555, 32'h1, 5'd9, 5'd9, 5'd9, 16'd40, 1'b0, 32'd0, 0, 0, 0);
    wait_ring(20, "t8_ring_start");
    rst_n = 1'b0;
    @(negedge wb_clk_i);
    check("t8_ring_en", 64'(ring_en), 64'd0);
    check("t8_busy", 64'(busy), 64'd0);
    check("t8_result", 64'(result), 64'd0);
    check("t8_a_input", 64'(a_input), 64'd0);
    check("t8_ring_sel", 64'(ring_sel), 64'd0);
    rst_n = 1'b1;

    repeat (5) @(negedge wb_clk_i);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
